// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit packet scheduler: packet type codes,
// frame sizes, SYNC pattern and scheduler state encodings.
package usb_pkg;

    localparam logic [1:0] PKT_TOKEN  = 2'b01;
    localparam logic [1:0] PKT_DATA   = 2'b11;
    localparam logic [1:0] PKT_HSHAKE = 2'b10;

    localparam int TOKEN_SIZE  = 27;
    localparam int DATA_SIZE   = 80;
    localparam int HSHAKE_SIZE = 16;

    localparam int FRAME_W = DATA_SIZE;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t IDLE     = 3'd0;
    localparam sched_state_t TYPE     = 3'd1;
    localparam sched_state_t SHIFT    = 3'd2;
    localparam sched_state_t END      = 3'd3;
    localparam sched_state_t WAIT_END = 3'd4;
    localparam sched_state_t GAP      = 3'd5;

    // The PID byte carries the check nibble in its upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_tx_pkt_sched_if.sv
// Request/grant bundle for the three requesters plus the CRC-stage link and
// scheduler status, shared between the scheduler (slave) and its clients (master).
interface usb_tx_pkt_sched_if;

    logic        hs_req;
    logic [3:0]  hs_pid;
    logic        hs_gnt;

    logic        tok_req;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        tok_gnt;

    logic        data_req;
    logic [3:0]  data_pid;
    logic [63:0] data_payload;
    logic        data_gnt;

    logic [1:0]  pkt_in;
    logic        s_in;
    logic        endr;
    logic        endb;

    logic        busy;
    logic        pkt_done;
    logic        err_timeout;

    modport master (
        output hs_req, hs_pid,
        output tok_req, tok_pid, tok_addr, tok_endp,
        output data_req, data_pid, data_payload,
        output endb,
        input  hs_gnt, tok_gnt, data_gnt,
        input  pkt_in, s_in, endr,
        input  busy, pkt_done, err_timeout
    );

    modport slave (
        input  hs_req, hs_pid,
        input  tok_req, tok_pid, tok_addr, tok_endp,
        input  data_req, data_pid, data_payload,
        input  endb,
        output hs_gnt, tok_gnt, data_gnt,
        output pkt_in, s_in, endr,
        output busy, pkt_done, err_timeout
    );

endinterface

// File: rtl/counter.sv
// Generic up-counter with synchronous reset, synchronous clear and count enable.
module counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register; bit 0 is presented first and the
// register shifts right on each enabled cycle.
module piso_shifter #(
    parameter int W = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    output logic         bit_out
);

    logic [W-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= din;
        end else if (shift) begin
            r_sr <= {1'b0, r_sr[W-1:1]};
        end
    end

    assign bit_out = r_sr[0];

endmodule

// File: rtl/usb_tx_pkt_sched.sv
// Transmit packet scheduler: arbitrates handshake/token/data requests, serializes
// the winning frame LSB-first to the CRC stage and paces packets on endb.
module usb_tx_pkt_sched
    import usb_pkg::*;
#(
    parameter int IFG_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic clk,
    input  logic rst,
    usb_tx_pkt_sched_if.slave bus
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    sched_state_t        r_state;
    sched_state_t        w_next;
    logic [1:0]          r_code;
    logic [6:0]          r_len;

    logic                w_hs_gnt;
    logic                w_tok_gnt;
    logic                w_data_gnt;
    logic                w_any_gnt;

    logic [FRAME_W-1:0]  w_frame;
    logic [1:0]          w_code;
    logic [6:0]          w_len;

    logic [6:0]          w_bitcnt;
    logic [WW-1:0]       w_wdog;
    logic [GW-1:0]       w_gapcnt;

    logic                w_sr_bit;
    logic                w_shift_done;
    logic                w_wd_expire;
    logic                w_gap_done;

    // Fixed priority hs > tok > data, only while idle and never during reset.
    assign w_hs_gnt   = (r_state == IDLE) && !rst && bus.hs_req;
    assign w_tok_gnt  = (r_state == IDLE) && !rst && !bus.hs_req && bus.tok_req;
    assign w_data_gnt = (r_state == IDLE) && !rst && !bus.hs_req && !bus.tok_req && bus.data_req;
    assign w_any_gnt  = w_hs_gnt || w_tok_gnt || w_data_gnt;

    always_comb begin
        w_frame = '0;
        w_code  = PKT_HSHAKE;
        w_len   = 7'(HSHAKE_SIZE);
        if (w_hs_gnt) begin
            w_frame[HSHAKE_SIZE-1:0] = {pid_byte(bus.hs_pid), SYNC_BYTE};
        end else if (w_tok_gnt) begin
            w_frame[TOKEN_SIZE-1:0] = {bus.tok_endp, bus.tok_addr, pid_byte(bus.tok_pid), SYNC_BYTE};
            w_code                  = PKT_TOKEN;
            w_len                   = 7'(TOKEN_SIZE);
        end else if (w_data_gnt) begin
            w_frame = {bus.data_payload, pid_byte(bus.data_pid), SYNC_BYTE};
            w_code  = PKT_DATA;
            w_len   = 7'(DATA_SIZE);
        end
    end

    piso_shifter #(.W(FRAME_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (w_any_gnt),
        .din     (w_frame),
        .shift   (r_state == SHIFT),
        .bit_out (w_sr_bit)
    );

    counter #(.W(7)) u_bitcnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (r_state == IDLE),
        .en    (r_state == SHIFT),
        .count (w_bitcnt)
    );

    counter #(.W(WW)) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (r_state != WAIT_END),
        .en    (r_state == WAIT_END),
        .count (w_wdog)
    );

    counter #(.W(GW)) u_gapcnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (r_state != GAP),
        .en    (r_state == GAP),
        .count (w_gapcnt)
    );

    assign w_shift_done = (w_bitcnt == (r_len - 7'd1));
    assign w_wd_expire  = (r_state == WAIT_END) && (w_wdog == WW'(TIMEOUT));
    assign w_gap_done   = (w_gapcnt == GW'(IFG_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_any_gnt) w_next = TYPE;
            TYPE:     w_next = SHIFT;
            SHIFT:    if (w_shift_done) w_next = END;
            END:      w_next = WAIT_END;
            WAIT_END: begin
                if (bus.endb || w_wd_expire) begin
                    w_next = (IFG_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP:      if (w_gap_done) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_next;
            if (w_any_gnt) begin
                r_code <= w_code;
                r_len  <= w_len;
            end
        end
    end

    assign bus.hs_gnt      = w_hs_gnt;
    assign bus.tok_gnt     = w_tok_gnt;
    assign bus.data_gnt    = w_data_gnt;
    assign bus.pkt_in      = (r_state == TYPE) ? r_code : 2'b00;
    assign bus.s_in        = (r_state == SHIFT) && w_sr_bit;
    assign bus.endr        = (r_state == END);
    assign bus.busy        = (r_state != IDLE);
    // endb wins over a simultaneous watchdog expiry.
    assign bus.pkt_done    = (r_state == WAIT_END) && bus.endb;
    assign bus.err_timeout = w_wd_expire && !bus.endb;

endmodule

// File: tb/tb_usb_tx_pkt_sched.sv
// Directed scoreboard bench for usb_tx_pkt_sched: expected frames are queued at
// grant time and compared when the CRC-side framing reports end of raw bits.
module tb_usb_tx_pkt_sched;

    typedef struct {
        logic [1:0]  code;
        int          len;
        logic [79:0] bits;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    pkt_t expQ[$];
    pkt_t monExp;
    logic monBusy = 1'b0;
    int   obsLen;
    logic [79:0] obsBits;
    logic [1:0]  obsCode;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    usb_tx_pkt_sched_if bus();

    usb_tx_pkt_sched #(.IFG_CYCLES(2), .TIMEOUT(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [9:0] outVec();
        return {bus.hs_gnt, bus.tok_gnt, bus.data_gnt, bus.pkt_in, bus.s_in,
                bus.endr, bus.busy, bus.pkt_done, bus.err_timeout};
    endfunction

    // Frames written out in time order: bit i of .bits is the i-th serial bit.
    function automatic pkt_t expectedPkt(input int kind);
        pkt_t p;
        case (kind)
            0: begin p.code = 2'b10; p.len = 16; p.bits = 80'h0_D280; end
            1: begin p.code = 2'b01; p.len = 27; p.bits = 80'h185_E180; end
            default: begin p.code = 2'b11; p.len = 80; p.bits = {64'h0123_4567_89AB_CDEF, 8'hC3, 8'h80}; end
        endcase
        return p;
    endfunction

    task automatic applyStimulus(input int kind, input logic on);
        case (kind)
            0: bus.hs_req = on;
            1: bus.tok_req = on;
            default: bus.data_req = on;
        endcase
    endtask

    task automatic waitSignal(input int sel, input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            case (sel)
                0: got = bus.hs_gnt | bus.tok_gnt | bus.data_gnt;
                1: got = bus.endr;
                default: got = bus.err_timeout;
            endcase
        end
    endtask

    // Serve one packet end to end; returns grant and pkt_done cycles.
    task automatic serviceOne(input int kind, input int prevDone, output int grantCyc, output int doneCyc);
        pkt_t e;
        logic got;
        int g;
        e = expectedPkt(kind);
        waitSignal(0, 60, got);
        checkOutput("grant_seen", got, 1);
        g = cyc;
        grantCyc = g;
        checkOutput("grant_vec", {bus.hs_gnt, bus.tok_gnt, bus.data_gnt},
                    (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001);
        checkOutput("busy_at_grant", bus.busy, 0);
        if (prevDone >= 0) checkOutput("grant_gap", g - prevDone, 3);
        expQ.push_back(e);
        @(posedge clk); #1 applyStimulus(kind, 1'b0);
        @(negedge clk);
        checkOutput("pkt_in_code", bus.pkt_in, e.code);
        checkOutput("busy_type", bus.busy, 1);
        waitSignal(1, 200, got);
        checkOutput("endr_seen", got, 1);
        checkOutput("endr_cycle", cyc - g, e.len + 2);
        @(posedge clk); #1 bus.endb = 1'b1;
        @(negedge clk);
        checkOutput("pkt_done_err", {bus.pkt_done, bus.err_timeout}, 2'b10);
        doneCyc = cyc;
        @(posedge clk); #1 bus.endb = 1'b0;
    endtask

    // Collect the serial bits between the type cycle and endr, then score them.
    always @(negedge clk) begin
        if (rst) begin
            monBusy = 1'b0;
        end else if (bus.pkt_in != 2'b00) begin
            monBusy = 1'b1;
            obsCode = bus.pkt_in;
            obsLen  = 0;
            obsBits = '0;
        end else if (monBusy && bus.endr) begin
            monBusy = 1'b0;
            checkOutput("s_in_at_endr", bus.s_in, 0);
            if (expQ.size() == 0) begin
                checkOutput("scoreboard_empty", 1, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("frame_code", obsCode, monExp.code);
                checkOutput("frame_len", obsLen, monExp.len);
                checkOutput("frame_bits", obsBits, monExp.bits);
            end
        end else if (monBusy) begin
            if (obsLen < 80) obsBits[obsLen] = bus.s_in;
            obsLen++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int d;
        int g;
        int endCyc;
        int relCyc;
        logic got;
        logic sawDone;

        rst = 1'b1;
        bus.hs_req = 1'b0;   bus.hs_pid = 4'b0010;
        bus.tok_req = 1'b0;  bus.tok_pid = 4'b0001; bus.tok_addr = 7'h05; bus.tok_endp = 4'h3;
        bus.data_req = 1'b0; bus.data_pid = 4'b0011; bus.data_payload = 64'h0123_4567_89AB_CDEF;
        bus.endb = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", outVec(), 10'd0);
        @(posedge clk); #1 rst = 1'b0;

        bus.endb = 1'b1;
        @(negedge clk);
        checkOutput("endb_in_idle", {bus.pkt_done, bus.err_timeout, bus.busy}, 3'b000);
        @(posedge clk); #1 bus.endb = 1'b0;

        $display("[TB] ACK handshake");
        applyStimulus(0, 1'b1);
        serviceOne(0, -1, g, d);
        @(negedge clk); checkOutput("gap_busy_1", bus.busy, 1);
        @(negedge clk); checkOutput("gap_busy_2", bus.busy, 1);
        @(negedge clk); checkOutput("idle_after_gap", bus.busy, 0);

        $display("[TB] token");
        @(posedge clk); #1 applyStimulus(1, 1'b1);
        serviceOne(1, -1, g, d);

        $display("[TB] data");
        repeat (4) @(posedge clk);
        #1 applyStimulus(2, 1'b1);
        serviceOne(2, -1, g, d);

        $display("[TB] contention");
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(0, 1'b1);
        applyStimulus(1, 1'b1);
        applyStimulus(2, 1'b1);
        serviceOne(0, -1, g, d);
        serviceOne(1, d, g, d);
        serviceOne(2, d, g, d);

        $display("[TB] watchdog timeout");
        repeat (4) @(posedge clk);
        #1 applyStimulus(1, 1'b1);
        waitSignal(0, 60, got);
        checkOutput("to_grant_seen", got, 1);
        expQ.push_back(expectedPkt(1));
        @(posedge clk); #1 applyStimulus(1, 1'b0);
        waitSignal(1, 200, got);
        checkOutput("to_endr_seen", got, 1);
        endCyc = cyc;
        sawDone = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.pkt_done) sawDone = 1'b1;
            got = bus.err_timeout;
        end
        checkOutput("err_timeout_seen", got, 1);
        checkOutput("err_timeout_cycle", cyc - endCyc, 21);
        checkOutput("no_pkt_done_on_timeout", sawDone, 0);
        @(negedge clk); checkOutput("to_gap_busy", bus.busy, 1);
        @(negedge clk);
        @(negedge clk); checkOutput("to_back_idle", bus.busy, 0);

        $display("[TB] reset mid-packet");
        @(posedge clk); #1 applyStimulus(1, 1'b1);
        waitSignal(0, 60, got);
        checkOutput("rst_grant_seen", got, 1);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_outputs_zero", outVec(), 10'd0);
        @(posedge clk); #1 rst = 1'b0;
        relCyc = cyc;
        serviceOne(1, -1, g, d);
        checkOutput("regrant_after_reset", g - relCyc, 0);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
